// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared state encoding and sizing constants for the 1x3 router.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int ADDR_W            = 2;
    localparam int NUM_PORTS_DEFAULT = 3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
// Module   : router_fsm
// Brief    : Control FSM sequencing header decode, payload, stall and parity.
// Revision : 1.0 - initial release
// ============================================================================
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    d_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy
);

    localparam logic [ADDR_W:0] c_num_ports = (ADDR_W+1)'(NUM_PORTS);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          w_empty_ext;
    logic [3:0]          w_srst_ext;
    logic                w_addr_ok;

    // Zero-extend per-port flags so any 2-bit address indexes safely.
    assign w_empty_ext = 4'(fifo_empty);
    assign w_srst_ext  = 4'(soft_reset);
    assign w_addr_ok   = ({1'b0, d_in} < c_num_ports);

    always_comb begin
        w_next = r_state;
        if (r_state != DECODE_ADDRESS && w_srst_ext[r_addr]) begin
            w_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && w_addr_ok)
                        w_next = w_empty_ext[d_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_empty_ext[r_addr]) w_next = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: w_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       w_next = FIFO_FULL_STATE;
                    else if (!pkt_valid) w_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) w_next = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        w_next = DECODE_ADDRESS;
                    else if (low_pkt_valid) w_next = LOAD_PARITY;
                    else                    w_next = LOAD_DATA;
                end
                LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:            w_next = DECODE_ADDRESS;
            endcase
        end
    end

    // Outputs are registered from the next state so they always match r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= DECODE_ADDRESS;
            r_addr        <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE_ADDRESS && pkt_valid) r_addr <= d_in;
            detect_add    <= (w_next == DECODE_ADDRESS);
            lfd_state     <= (w_next == LOAD_FIRST_DATA);
            ld_state      <= (w_next == LOAD_DATA);
            laf_state     <= (w_next == LOAD_AFTER_FULL);
            full_state    <= (w_next == FIFO_FULL_STATE);
            rst_int_reg   <= (w_next == CHECK_PARITY_ERROR);
            write_enb_reg <= (w_next == LOAD_DATA) || (w_next == LOAD_PARITY)
                          || (w_next == LOAD_AFTER_FULL);
            busy          <= (w_next != DECODE_ADDRESS) && (w_next != LOAD_DATA);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fsm
// Brief    : Scoreboard bench for router_fsm against a packet-phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fsm;

    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_valid;
    logic [1:0]    d_in;
    logic          fifo_full;
    logic [NP-1:0] fifo_empty;
    logic [NP-1:0] soft_reset;
    logic          parity_done;
    logic          low_pkt_valid;
    logic          detect_add, lfd_state, ld_state, laf_state;
    logic          full_state, rst_int_reg, write_enb_reg, busy;

    router_fsm #(.NUM_PORTS(NP)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .d_in(d_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    // Packet phases as seen by the packet source, independent of any encoding.
    typedef enum int {P_HEADER, P_FIRST, P_PAYLOAD, P_PARITY,
                      P_STALL, P_RESUME, P_WAIT, P_CHECK} phase_t;

    phase_t     m_phase = P_HEADER;
    int         m_addr  = 0;
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    bit         done    = 0;

    function automatic bit port_bit(input logic [NP-1:0] v, input int idx);
        return (idx < NP) ? v[idx] : 1'b0;
    endfunction

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    function automatic logic [7:0] expect_of(input phase_t p);
        case (p)
            P_HEADER:  return 8'b1000_0000;
            P_FIRST:   return 8'b0100_0001;
            P_PAYLOAD: return 8'b0010_0010;
            P_PARITY:  return 8'b0000_0011;
            P_STALL:   return 8'b0000_1001;
            P_RESUME:  return 8'b0001_0011;
            P_WAIT:    return 8'b0000_0001;
            default:   return 8'b0000_0101;
        endcase
    endfunction

    task automatic model_advance();
        phase_t nxt = m_phase;
        int     d   = int'(d_in);
        if (!rst) begin
            m_phase = P_HEADER;
            m_addr  = 0;
            return;
        end
        if (m_phase != P_HEADER && port_bit(soft_reset, m_addr)) nxt = P_HEADER;
        else case (m_phase)
            P_HEADER:  if (pkt_valid && d < NP) nxt = port_bit(fifo_empty, d) ? P_FIRST : P_WAIT;
            P_WAIT:    if (port_bit(fifo_empty, m_addr)) nxt = P_FIRST;
            P_FIRST:   nxt = P_PAYLOAD;
            P_PAYLOAD: nxt = fifo_full ? P_STALL : (!pkt_valid ? P_PARITY : P_PAYLOAD);
            P_STALL:   if (!fifo_full) nxt = P_RESUME;
            P_RESUME:  nxt = parity_done ? P_HEADER : (low_pkt_valid ? P_PARITY : P_PAYLOAD);
            P_PARITY:  nxt = P_CHECK;
            default:   nxt = fifo_full ? P_STALL : P_HEADER;
        endcase
        if (m_phase == P_HEADER && pkt_valid) m_addr = d;
        m_phase = nxt;
    endtask

    task automatic step(input logic r, input logic pv, input logic [1:0] d, input logic ff,
                        input logic [NP-1:0] fe, input logic [NP-1:0] sr,
                        input logic pd, input logic lpv);
        @(negedge clk);
        rst = r; pkt_valid = pv; d_in = d; fifo_full = ff;
        fifo_empty = fe; soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
        model_advance();
        exp_q.push_back(expect_of(m_phase));
    endtask

    task automatic go(input logic pv, input logic [1:0] d, input logic ff,
                      input logic [NP-1:0] fe, input logic [NP-1:0] sr,
                      input logic pd, input logic lpv);
        step(1'b1, pv, d, ff, fe, sr, pd, lpv);
    endtask

    // Monitor: compares one expected vector per clock, just after the edge.
    initial begin
        logic [7:0] got, exp_v;
        while (!done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got = {detect_add, lfd_state, ld_state, laf_state,
                       full_state, rst_int_reg, write_enb_reg, busy};
                n_tests++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, got, exp_v);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; pkt_valid = 1'b0; d_in = 2'b00; fifo_full = 1'b0;
        fifo_empty = '1; soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;

        step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        repeat (2) go(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

        // Normal packet to port 1
        go(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        repeat (8) go(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        repeat (3) go(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

        // Wait for port 2, then full stalls
        go(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
        repeat (2) go(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
        go(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        repeat (4) go(1'b1, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b0, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1);
        repeat (3) go(1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1);

        // Soft reset of a foreign port ignored, own port honoured
        go(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
        go(1'b0, 2'd0, 1'b0, 3'b110, 3'b100, 1'b0, 1'b0);
        go(1'b0, 2'd0, 1'b0, 3'b110, 3'b001, 1'b0, 1'b0);

        // Invalid address
        repeat (5) go(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

        // Reset in the middle of a packet
        go(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        go(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

        // Randomised traffic with shifting biases
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 600; i++) begin
                logic [NP-1:0] fe, sr;
                for (int b = 0; b < NP; b++) begin
                    fe[b] = ($urandom_range(99) < 40 + 10 * seg);
                    sr[b] = ($urandom_range(199) < 3);
                end
                step(($urandom_range(499) != 0),
                     ($urandom_range(99) < 80),
                     2'($urandom_range(3)),
                     ($urandom_range(99) < 5 + 5 * seg),
                     fe, sr,
                     ($urandom_range(99) < 25),
                     ($urandom_range(99) < 25));
            end
        end

        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            @(posedge clk);
            #2;
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain leftover=%0d required=0", exp_q.size());
            end
        end
        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control state machine for the 1x3 router. It sequences header decode, payload load, FIFO-full stall and parity check.
- It drives the state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) consumed by router_register.
- It drives write_enb_reg toward the synchroniser/FIFO stage and busy back to the packet source.
- It consumes parity_done and low_pkt_valid from router_register, plus per-port FIFO empty/full and soft-reset status.

Parameters:
- NUM_PORTS, 3, number of output FIFOs. Legal range 2..4, since the address is d_in[1:0]; any address >= NUM_PORTS is invalid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  packet source has a valid byte on d_in.
- d_in  in  2  header address field (bits [1:0] of the data byte).
- fifo_full  in  1  full flag of the currently selected FIFO.
- fifo_empty  in  NUM_PORTS  per-port FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-port read-timeout soft reset.
- parity_done  in  1  from router_register: parity byte captured.
- low_pkt_valid  in  1  from router_register: pkt_valid fell while stalled.
- detect_add  out  1  high in DECODE_ADDRESS.
- lfd_state  out  1  high in LOAD_FIRST_DATA.
- ld_state  out  1  high in LOAD_DATA.
- laf_state  out  1  high in LOAD_AFTER_FULL.
- full_state  out  1  high in FIFO_FULL_STATE.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  FIFO write enable.
- busy  out  1  source must hold its byte.

Behaviour:
- Moore machine with one state register. All outputs decode only from that register, with no input-to-output combinational path.
- Reset (rst=0, async): state=DECODE_ADDRESS, addr_q=0. Outputs during reset: detect_add=1, all other outputs 0.
- addr_q (2-bit) loads d_in on every clk while in DECODE_ADDRESS with pkt_valid=1. It holds in all other states.
- Transitions are evaluated at the rising edge of clk. Conditions are listed in priority order.
- Global (highest priority, any state except DECODE_ADDRESS): soft_reset[addr_q]=1 -> DECODE_ADDRESS.
- DECODE_ADDRESS:
  - pkt_valid & d_in<NUM_PORTS & fifo_empty[d_in] -> LOAD_FIRST_DATA.
  - pkt_valid & d_in<NUM_PORTS & !fifo_empty[d_in] -> WAIT_TILL_EMPTY.
  - Otherwise, including an invalid address, stay.
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: unconditionally -> LOAD_DATA. Exactly 1 cycle.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: unconditionally -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- write_enb_reg = 1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Simultaneous events:
  - fifo_full and pkt_valid falling together in LOAD_DATA: the full branch wins.
  - soft_reset of a port other than addr_q is ignored.
- Unused state encodings -> DECODE_ADDRESS on the next clk.
- Reset asserted mid-packet: immediate return to DECODE_ADDRESS. No partial-packet recovery.

Decomposition:
- Shared package router_pkg holds:
  - the 3-bit state enumeration (DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, LOAD_DATA=2, LOAD_PARITY=3, FIFO_FULL_STATE=4, LOAD_AFTER_FULL=5, WAIT_TILL_EMPTY=6, CHECK_PARITY_ERROR=7);
  - the ADDR_W=2 constant;
  - the NUM_PORTS default.
- No sub-module. The block is a single state register plus next-state and output decode.

Test Plan:
- Reset: rst=0 for 10ns -> detect_add=1, busy=0, write_enb_reg=0; after release the state holds DECODE_ADDRESS with pkt_valid=0.
- Normal packet, addr=1, fifo_empty=3'b111:
  - pkt_valid=1, d_in=2'b01 -> next cycle lfd_state=1, busy=1.
  - Then ld_state=1, write_enb_reg=1, busy=0 for 8 payload cycles.
  - Dropping pkt_valid -> LOAD_PARITY (write_enb_reg=1, busy=1), then rst_int_reg=1 for 1 cycle, then detect_add=1.
- Wait: d_in=2'b10 with fifo_empty=3'b011 -> busy=1 and no lfd_state. Set fifo_empty[2]=1 -> lfd_state=1 on the next cycle.
- Full stall:
  - In LOAD_DATA raise fifo_full -> full_state=1, write_enb_reg=0, busy=1 for 4 cycles.
  - Drop fifo_full with parity_done=0, low_pkt_valid=0 -> laf_state=1 for 1 cycle, then ld_state=1.
  - Repeat the stall with low_pkt_valid=1 -> path is laf_state, then LOAD_PARITY.
- Soft reset: in WAIT_TILL_EMPTY with addr_q=0, pulse soft_reset=3'b001 -> detect_add=1 next cycle. Pulsing soft_reset=3'b100 instead leaves the state unchanged.
- Invalid address: pkt_valid=1, d_in=2'b11 for 5 cycles -> detect_add stays 1, busy=0, no lfd_state.
